// File: rtl/ser2par_pkg.sv
// Shared types and width helper for the ser2par frame controller.
package ser2par_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    CAPTURE
  } ctrl_state_t;

  // Width able to hold every value 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/ser2par_ctrl_if.sv
// Pin-side strobes, deserializer link and word handshake of the ser2par controller.
interface ser2par_ctrl_if #(parameter int BITLEN = 8);
  import ser2par_pkg::*;

  logic              SerDataIn;
  logic              SerDataEn;
  logic              S2pDataIn;
  logic              S2pDataEn;
  logic [BITLEN-1:0] S2pParData;
  logic [BITLEN-1:0] WordData;
  logic              WordValid;
  logic              WordReady;

  // master is the controller, slave is the surrounding pins/ser2par/consumer.
  modport master (
    input  SerDataIn, SerDataEn, S2pParData, WordReady,
    output S2pDataIn, S2pDataEn, WordData, WordValid
  );

  modport slave (
    output SerDataIn, SerDataEn, S2pParData, WordReady,
    input  S2pDataIn, S2pDataEn, WordData, WordValid
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry synchronous FIFO; a pop in the same clock frees room for a push when full.
module word_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (doPush && !doPop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (doPop && !doPush) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ser2par_ctrl.sv
// Frame controller for the ser2par deserializer: gates bit strobes, counts bits,
// captures finished words into a 2-entry buffer and flags gap aborts and overruns.
module ser2par_ctrl
  import ser2par_pkg::*;
#(
  parameter int BITLEN  = 8,
  parameter int S2P_LAT = 1,
  parameter int GAP_MAX = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            CtrlEn,
  ser2par_ctrl_if.master  bus,
  output logic            Busy,
  output logic            ErrGap,
  output logic            ErrOvf
);

  localparam int BitW = cntWidth(BITLEN);
  localparam int GapW = cntWidth(GAP_MAX);
  localparam int LatW = cntWidth(S2P_LAT);
  // A zero-latency deserializer needs no settle state.
  localparam ctrl_state_t AfterWord = (S2P_LAT == 0) ? CAPTURE : WAIT;

  ctrl_state_t state_q, state_d;
  logic [BitW-1:0] bitCnt_q, bitCnt_d;
  logic [GapW-1:0] gapCnt_q, gapCnt_d;
  logic [LatW-1:0] latCnt_q, latCnt_d;

  logic [BitW-1:0] bitInc;
  logic [GapW-1:0] gapInc;
  logic [LatW-1:0] latInc;
  logic            fwdStrobe;
  logic            gapAbort;
  logic            capture;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            pop;

  assign fwdStrobe = bus.SerDataEn & CtrlEn & ((state_q == IDLE) | (state_q == SHIFT));
  assign bus.S2pDataEn = fwdStrobe;
  assign bus.S2pDataIn = bus.SerDataIn;

  assign bitInc = bitCnt_q + BitW'(1);
  assign gapInc = gapCnt_q + GapW'(1);
  assign latInc = latCnt_q + LatW'(1);

  assign capture = (state_q == CAPTURE) & CtrlEn;
  assign pop     = ~fifoEmpty & bus.WordReady;

  assign bus.WordValid = ~fifoEmpty;
  assign Busy          = (state_q != IDLE);
  assign ErrGap        = gapAbort;
  assign ErrOvf        = capture & fifoFull & ~pop;

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    gapCnt_d = gapCnt_q;
    latCnt_d = latCnt_q;
    gapAbort = 1'b0;
    if (!CtrlEn) begin
      state_d  = IDLE;
      bitCnt_d = '0;
      gapCnt_d = '0;
      latCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fwdStrobe) begin
            bitCnt_d = BitW'(1);
            gapCnt_d = '0;
            latCnt_d = '0;
            state_d  = (BITLEN == 1) ? AfterWord : SHIFT;
          end
        end
        SHIFT: begin
          if (fwdStrobe) begin
            bitCnt_d = bitInc;
            gapCnt_d = '0;
            if (bitInc == BitW'(BITLEN)) begin
              latCnt_d = '0;
              state_d  = AfterWord;
            end
          end else if (gapInc == GapW'(GAP_MAX)) begin
            gapAbort = 1'b1;
            bitCnt_d = '0;
            gapCnt_d = '0;
            state_d  = IDLE;
          end else begin
            gapCnt_d = gapInc;
          end
        end
        WAIT: begin
          if (latInc == LatW'(S2P_LAT)) begin
            latCnt_d = '0;
            state_d  = CAPTURE;
          end else begin
            latCnt_d = latInc;
          end
        end
        CAPTURE: begin
          bitCnt_d = '0;
          gapCnt_d = '0;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      gapCnt_q <= '0;
      latCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      gapCnt_q <= gapCnt_d;
      latCnt_q <= latCnt_d;
    end
  end

  word_fifo2 #(.WIDTH(BITLEN)) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .push_i  (capture),
    .pop_i   (pop),
    .data_i  (bus.S2pParData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (bus.WordData)
  );

endmodule

// File: tb/tb_ser2par_ctrl.sv
// Scoreboard bench for ser2par_ctrl with a behavioural LSB-first deserializer.
module tb_ser2par_ctrl;

  localparam int BITLEN  = 8;
  localparam int S2P_LAT = 1;
  localparam int GAP_MAX = 16;

  logic Clk = 1'b0;
  logic Rst;
  logic CtrlEn;
  logic Busy;
  logic ErrGap;
  logic ErrOvf;

  ser2par_ctrl_if #(.BITLEN(BITLEN)) bus ();

  ser2par_ctrl #(
    .BITLEN  (BITLEN),
    .S2P_LAT (S2P_LAT),
    .GAP_MAX (GAP_MAX)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .CtrlEn (CtrlEn),
    .bus    (bus),
    .Busy   (Busy),
    .ErrGap (ErrGap),
    .ErrOvf (ErrOvf)
  );

  always #5 Clk = ~Clk;

  // Stand-in for ser2par: bit i of a word ends up at position i.
  logic [BITLEN-1:0] shiftReg = '0;
  always @(posedge Clk) begin
    if (bus.S2pDataEn) shiftReg <= {bus.S2pDataIn, shiftReg[BITLEN-1:1]};
  end
  assign bus.S2pParData = shiftReg;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int busyCycles = 0;
  int errGapCnt = 0;
  int errOvfCnt = 0;
  int errGapCyc = 0;
  int lastPopCyc = 0;
  int lastStrobeCyc = 0;
  logic [BITLEN-1:0] expQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Pops and compares every accepted word against the scoreboard.
  always @(negedge Clk) begin
    if (Busy) busyCycles++;
    if (ErrGap) begin
      errGapCnt++;
      errGapCyc = cyc;
    end
    if (ErrOvf) errOvfCnt++;
    if (bus.WordValid && bus.WordReady) begin
      lastPopCyc = cyc;
      if (expQ.size() > 0) checkOutput("word", 32'(bus.WordData), 32'(expQ.pop_front()));
      else checkOutput("spuriousValid", 32'(bus.WordValid), 32'd0);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [BITLEN-1:0] word, input int nBits, input int gap);
    for (int i = 0; i < nBits; i++) begin
      bus.SerDataIn = word[i];
      bus.SerDataEn = 1'b1;
      lastStrobeCyc = cyc;
      waitCycles(1);
      if (gap > 0) begin
        bus.SerDataEn = 1'b0;
        bus.SerDataIn = 1'b0;
        waitCycles(gap);
      end
    end
    bus.SerDataEn = 1'b0;
    bus.SerDataIn = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_s2pEn"}, 32'(bus.S2pDataEn), 32'd0);
    checkOutput({tag, "_errGap"}, 32'(ErrGap), 32'd0);
    checkOutput({tag, "_errOvf"}, 32'(ErrOvf), 32'd0);
  endtask

  initial begin
    int b0;
    int g0;
    int o0;
    Rst = 1'b1;
    CtrlEn = 1'b1;
    bus.SerDataIn = 1'b0;
    bus.SerDataEn = 1'b0;
    bus.WordReady = 1'b1;
    waitCycles(3);
    Rst = 1'b0;
    checkIdleOutputs("reset");
    checkOutput("reset_valid", 32'(bus.WordValid), 32'd0);
    checkOutput("reset_data", 32'(bus.WordData), 32'd0);
    checkOutput("reset_s2pIn", 32'(bus.S2pDataIn), 32'd0);

    // Back-to-back word: latency and Busy window.
    b0 = busyCycles;
    expQ.push_back(8'h2B);
    applyStimulus(8'h2B, BITLEN, 0);
    waitCycles(6);
    checkOutput("latency", 32'(lastPopCyc - lastStrobeCyc), 32'(S2P_LAT + 2));
    checkOutput("busyCycles", 32'(busyCycles - b0), 32'(BITLEN + S2P_LAT));
    checkOutput("drain_b2b", 32'(expQ.size()), 32'd0);

    // Spaced bits below the gap limit.
    g0 = errGapCnt;
    expQ.push_back(8'h2B);
    applyStimulus(8'h2B, BITLEN, 3);
    waitCycles(6);
    checkOutput("spaced_noGap", 32'(errGapCnt - g0), 32'd0);
    checkOutput("drain_spaced", 32'(expQ.size()), 32'd0);

    // Gap abort after 4 bits, then a clean word.
    g0 = errGapCnt;
    applyStimulus(8'h0F, 4, 0);
    waitCycles(GAP_MAX + 4);
    checkOutput("gap_count", 32'(errGapCnt - g0), 32'd1);
    checkOutput("gap_timing", 32'(errGapCyc - lastStrobeCyc), 32'(GAP_MAX));
    checkOutput("gap_busy", 32'(Busy), 32'd0);
    checkOutput("gap_valid", 32'(bus.WordValid), 32'd0);
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, BITLEN, 0);
    waitCycles(6);
    checkOutput("drain_gap", 32'(expQ.size()), 32'd0);

    // Overrun: third word dropped while consumer stalls.
    bus.WordReady = 1'b0;
    o0 = errOvfCnt;
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    applyStimulus(8'h11, BITLEN, 0);
    waitCycles(4);
    applyStimulus(8'h22, BITLEN, 0);
    waitCycles(4);
    applyStimulus(8'h33, BITLEN, 0);
    waitCycles(4);
    checkOutput("ovf_count", 32'(errOvfCnt - o0), 32'd1);
    checkOutput("ovf_valid", 32'(bus.WordValid), 32'd1);
    checkOutput("ovf_head", 32'(bus.WordData), 32'h11);
    bus.WordReady = 1'b1;
    waitCycles(4);
    checkOutput("ovf_emptied", 32'(bus.WordValid), 32'd0);
    checkOutput("drain_ovf", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a word.
    g0 = errGapCnt;
    applyStimulus(8'hFF, 5, 0);
    Rst = 1'b1;
    waitCycles(1);
    Rst = 1'b0;
    checkIdleOutputs("midRst");
    checkOutput("midRst_valid", 32'(bus.WordValid), 32'd0);
    checkOutput("midRst_data", 32'(bus.WordData), 32'd0);
    waitCycles(GAP_MAX + 4);
    checkOutput("midRst_noGap", 32'(errGapCnt - g0), 32'd0);
    expQ.push_back(8'h5A);
    applyStimulus(8'h5A, BITLEN, 0);
    waitCycles(6);
    checkOutput("drain_midRst", 32'(expQ.size()), 32'd0);

    // CtrlEn dropped mid-word keeps the buffered word.
    bus.WordReady = 1'b0;
    expQ.push_back(8'h77);
    applyStimulus(8'h77, BITLEN, 0);
    waitCycles(4);
    g0 = errGapCnt;
    applyStimulus(8'hFF, 5, 0);
    CtrlEn = 1'b0;
    waitCycles(GAP_MAX + 4);
    bus.SerDataEn = 1'b1;
    #1;
    checkOutput("ctrlOff_blocked", 32'(bus.S2pDataEn), 32'd0);
    bus.SerDataEn = 1'b0;
    #1;
    checkIdleOutputs("ctrlOff");
    checkOutput("ctrlOff_noGap", 32'(errGapCnt - g0), 32'd0);
    checkOutput("ctrlOff_valid", 32'(bus.WordValid), 32'd1);
    checkOutput("ctrlOff_head", 32'(bus.WordData), 32'h77);
    CtrlEn = 1'b1;
    waitCycles(1);
    bus.WordReady = 1'b1;
    waitCycles(3);
    expQ.push_back(8'h5A);
    applyStimulus(8'h5A, BITLEN, 0);
    waitCycles(6);
    checkOutput("drain_ctrlOff", 32'(expQ.size()), 32'd0);

    // Capture into a full buffer while the consumer pops in the same clock.
    bus.WordReady = 1'b0;
    expQ.push_back(8'h01);
    expQ.push_back(8'h02);
    expQ.push_back(8'h03);
    applyStimulus(8'h01, BITLEN, 0);
    waitCycles(4);
    applyStimulus(8'h02, BITLEN, 0);
    waitCycles(4);
    o0 = errOvfCnt;
    applyStimulus(8'h03, BITLEN, 0);
    waitCycles(S2P_LAT);
    bus.WordReady = 1'b1;
    waitCycles(1);
    bus.WordReady = 1'b0;
    checkOutput("fullPop_noOvf", 32'(errOvfCnt - o0), 32'd0);
    checkOutput("fullPop_valid", 32'(bus.WordValid), 32'd1);
    checkOutput("fullPop_head", 32'(bus.WordData), 32'h02);
    bus.WordReady = 1'b1;
    waitCycles(4);
    checkOutput("fullPop_emptied", 32'(bus.WordValid), 32'd0);
    checkOutput("drain_fullPop", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ser2par_ctrl.md
Name: ser2par_ctrl

Overview:
- Frame controller that sequences the ser2par deserializer.
- Gates the incoming serial bit strobes and counts bits per word.
- Captures the deserializer's parallel output once a full word has shifted in, and presents completed words on a valid/ready handshake through a 2-entry buffer.
- Detects inter-bit gaps (aborts the partial word) and buffer overrun.
- Sits between the serial input pins and the ser2par instance; the consumer is the downstream register/bus logic.

Parameters:
- BITLEN, 8, bits per word; must match the ser2par bitlen; range 2..32.
- S2P_LAT, 1, clocks from the last S2pDataEn strobe until S2pParData is stable.
- GAP_MAX, 16, maximum idle clocks between bits inside a word before abort; range ≥1.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- CtrlEn  in  1  controller enable; low forces IDLE and blocks strobes.
- SerDataIn  in  1  serial bit from pin side.
- SerDataEn  in  1  bit-valid strobe from pin side.
- S2pDataIn  out  1  serial bit to ser2par.SerDataIn.
- S2pDataEn  out  1  strobe to ser2par.SerDataEn.
- S2pParData  in  BITLEN  ser2par.ParDataOut.
- WordData  out  BITLEN  head-of-buffer word.
- WordValid  out  1  buffer non-empty.
- WordReady  in  1  consumer accepts the head word when WordValid & WordReady.
- Busy  out  1  state ≠ IDLE.
- ErrGap  out  1  one-clock pulse on gap abort.
- ErrOvf  out  1  one-clock pulse when a captured word is dropped.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - State IDLE; bit count 0; gap count 0; buffer emptied.
  - S2pDataIn=0, S2pDataEn=0, WordData=0, WordValid=0, Busy=0, ErrGap=0, ErrOvf=0.
  - Reset mid-word discards the partial word; the deserializer content is don't-care because the next word overwrites all BITLEN bits.
- Strobe forwarding: S2pDataEn = SerDataEn & CtrlEn & (state IDLE or SHIFT). S2pDataIn = SerDataIn. Both are combinational, so the ser2par sees the bit in the same clock.
- State machine:
  - IDLE:
    - On a forwarded strobe: bit count becomes 1, gap count 0, go to SHIFT.
    - If BITLEN is reached on that strobe, go directly to WAIT.
  - SHIFT:
    - Each forwarded strobe increments bit count and clears gap count.
    - When the strobe brings the count to BITLEN, go to WAIT with latency count 0.
    - Each clock without a strobe increments gap count. When gap count reaches GAP_MAX: pulse ErrGap, clear counts, go to IDLE.
  - WAIT:
    - Strobes are blocked; extra pin strobes are ignored.
    - Count S2P_LAT clocks, then go to CAPTURE.
  - CAPTURE (one clock):
    - Sample S2pParData.
    - If the buffer is not full, push the word. If full, drop it and pulse ErrOvf. Same-clock pop frees space, so push succeeds when full & pop.
    - Go to IDLE.
- CtrlEn low: any state moves to IDLE next clock; the partial word is discarded without ErrGap; the buffer is preserved.
- Buffer:
  - 2-entry FIFO with pointer wrap at 2.
  - WordData is the head entry; it is 0 when empty.
  - WordValid = not empty.
  - Pop on WordValid & WordReady; WordReady with empty buffer has no effect.
- Latency: the last strobe at clock n gives WordValid=1 at clock n + S2P_LAT + 2 (empty buffer).
- Busy = state ≠ IDLE.

Decomposition:
- Package ser2par_pkg:
  - State enum ctrl_state_t {IDLE, SHIFT, WAIT, CAPTURE}.
  - Function clog2-based count widths.
- Sub-module word_fifo2: a 2-deep, BITLEN-wide synchronous FIFO (push/pop/full/empty/head). Reusable elsewhere.
- FSM, counters and strobe gating live in ser2par_ctrl.

Test Plan:
- Bench drives S2pParData from a behavioural LSB-first shift model (bit i lands at position i).
- Reset, then 8 back-to-back strobes carrying 0x2B LSB-first with WordReady=1 -> one WordValid pulse with WordData=0x2B exactly S2P_LAT+2 clocks after the last strobe; Busy high from the first strobe through CAPTURE.
- Bits of 0x2B spaced 3 idle clocks apart (GAP_MAX=16) -> WordData=0x2B, no ErrGap.
- 4 bits, then 16 idle clocks -> ErrGap pulses once at the 16th idle clock, state IDLE, no word. A following full 0xA5 word -> WordData=0xA5.
- WordReady=0; send 0x11, 0x22, 0x33 -> WordValid=1 with head 0x11, ErrOvf pulses once on the third capture. Then raise WordReady -> 0x11, 0x22 pop in order, then WordValid=0.
- Rst asserted after 5 bits, or CtrlEn dropped after 5 bits -> all outputs return to reset values (CtrlEn case keeps buffer contents), no ErrGap. The next full 0x5A word is received correctly.
- Buffer full with WordReady=1 and a capture in the same clock -> no ErrOvf, new word queued behind the remaining entry.
